// File: rtl/ai_move_gen.sv
// AI move selector: snapshots the board on start, then scans for a winning cell,
// a blocking cell, and finally the first free cell in center/corner/edge order.
module ai_move_gen #(
  parameter logic [1:0] AI_MARK  = 2'b10,
  parameter logic [1:0] OPP_MARK = 2'b01,
  parameter bit         BLOCK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] registers,
  input  logic        move_ack,
  output logic        busy,
  output logic        move_valid,
  output logic        no_move,
  output logic [1:0]  xoro,
  output logic [1:0]  row,
  output logic [1:0]  col
);

  typedef enum logic [2:0] {IDLE, WIN, BLOCK, PREF, DONE} state_t;

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [17:0] snapshot, snapshot_n;
  logic        valid_n, no_move_n;
  logic [1:0]  xoro_n, row_n, col_n;
  logic [1:0]  mark;
  logic [3:0]  pref_idx;

  function automatic logic [1:0] cell_at(input logic [17:0] b, input int k);
    logic [4:0] base;
    base = 5'(2 * k);
    return b[base +: 2];
  endfunction

  function automatic logic [3:0] rc_of(input logic [3:0] k);
    case (k)
      4'd0:    return 4'b0000;
      4'd1:    return 4'b0001;
      4'd2:    return 4'b0010;
      4'd3:    return 4'b0100;
      4'd4:    return 4'b0101;
      4'd5:    return 4'b0110;
      4'd6:    return 4'b1000;
      4'd7:    return 4'b1001;
      default: return 4'b1010;
    endcase
  endfunction

  // Empty cell whose row, column or diagonal already holds two of mark m
  function automatic logic line_hit(input logic [17:0] b, input logic [3:0] k, input logic [1:0] m);
    logic [3:0] rc;
    int r, c;
    logic h;
    rc = rc_of(k);
    r  = int'(rc[3:2]);
    c  = int'(rc[1:0]);
    h  = (cell_at(b, 3*r + (c+1)%3) == m) && (cell_at(b, 3*r + (c+2)%3) == m);
    h |= (cell_at(b, 3*((r+1)%3) + c) == m) && (cell_at(b, 3*((r+2)%3) + c) == m);
    if (r == c)
      h |= (cell_at(b, 4*((r+1)%3)) == m) && (cell_at(b, 4*((r+2)%3)) == m);
    if (r + c == 2)
      h |= (cell_at(b, 2*((r+1)%3) + 2) == m) && (cell_at(b, 2*((r+2)%3) + 2) == m);
    return (cell_at(b, int'(k)) == 2'b00) && h;
  endfunction

  function automatic logic [3:0] pref_cell(input logic [3:0] p);
    case (p)
      4'd0:    return 4'd4;
      4'd1:    return 4'd0;
      4'd2:    return 4'd2;
      4'd3:    return 4'd6;
      4'd4:    return 4'd8;
      4'd5:    return 4'd1;
      4'd6:    return 4'd3;
      4'd7:    return 4'd5;
      default: return 4'd7;
    endcase
  endfunction

  assign busy     = (state != IDLE);
  assign mark     = (state == WIN) ? AI_MARK : OPP_MARK;
  assign pref_idx = pref_cell(idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 4'd0;
      snapshot   <= 18'd0;
      move_valid <= 1'b0;
      no_move    <= 1'b0;
      xoro       <= 2'b00;
      row        <= 2'b00;
      col        <= 2'b00;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      snapshot   <= snapshot_n;
      move_valid <= valid_n;
      no_move    <= no_move_n;
      xoro       <= xoro_n;
      row        <= row_n;
      col        <= col_n;
    end
  end

  // In PREF, idx counts positions in the preference order rather than cells
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    snapshot_n = snapshot;
    valid_n    = move_valid;
    no_move_n  = no_move;
    xoro_n     = xoro;
    row_n      = row;
    col_n      = col;
    case (state)
      IDLE: begin
        if (start) begin
          snapshot_n = registers;
          state_n    = WIN;
          idx_n      = 4'd0;
        end
      end
      WIN, BLOCK: begin
        if (line_hit(snapshot, idx, mark)) begin
          state_n        = DONE;
          valid_n        = 1'b1;
          xoro_n         = AI_MARK;
          {row_n, col_n} = rc_of(idx);
        end else if (idx == 4'd8) begin
          idx_n   = 4'd0;
          state_n = (state == WIN && BLOCK_EN) ? BLOCK : PREF;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      PREF: begin
        if (cell_at(snapshot, int'(pref_idx)) == 2'b00) begin
          state_n        = DONE;
          idx_n          = pref_idx;
          valid_n        = 1'b1;
          xoro_n         = AI_MARK;
          {row_n, col_n} = rc_of(pref_idx);
        end else if (idx == 4'd8) begin
          state_n   = DONE;
          no_move_n = 1'b1;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      DONE: begin
        if (move_ack) begin
          state_n   = IDLE;
          idx_n     = 4'd0;
          valid_n   = 1'b0;
          no_move_n = 1'b0;
          xoro_n    = 2'b00;
          row_n     = 2'b00;
          col_n     = 2'b00;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ai_move_gen.sv
// Self-checking bench for ai_move_gen: a normal instance and an easy (BLOCK_EN=0)
// instance share stimulus; expected results are queued per scan and popped on completion.
module tb_ai_move_gen;

  logic        clk = 1'b0;
  logic        reset, start, move_ack;
  logic [17:0] registers;
  logic        busy, move_valid, no_move;
  logic [1:0]  xoro, row, col;
  logic        e_busy, e_valid, e_no_move;
  logic [1:0]  e_xoro, e_row, e_col;

  int          errors = 0;
  int          checks = 0;
  int          e_lat;
  logic [1:0]  e_row_s, e_col_s;

  typedef struct {
    logic [17:0] board;
    logic        valid;
    logic        nomove;
    logic [1:0]  row, col;
    int          lat;
    logic [1:0]  erow, ecol;
    int          elat;
  } vec_t;

  vec_t vecs[8];
  vec_t sbq[$];

  always #5 clk = ~clk;

  ai_move_gen #(.AI_MARK(2'b10), .OPP_MARK(2'b01), .BLOCK_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .registers(registers), .move_ack(move_ack),
    .busy(busy), .move_valid(move_valid), .no_move(no_move), .xoro(xoro), .row(row), .col(col));

  ai_move_gen #(.AI_MARK(2'b10), .OPP_MARK(2'b01), .BLOCK_EN(1'b0)) dut_easy (
    .clk(clk), .reset(reset), .start(start), .registers(registers), .move_ack(move_ack),
    .busy(e_busy), .move_valid(e_valid), .no_move(e_no_move), .xoro(e_xoro), .row(e_row), .col(e_col));

  function automatic logic [17:0] brd(input logic [8:0] xm, input logic [8:0] om, input logic [8:0] im);
    logic [17:0] b;
    b = 18'd0;
    for (int k = 0; k < 9; k++) begin
      if (xm[k])      b = b | (18'd2 << (2*k));
      else if (om[k]) b = b | (18'd1 << (2*k));
      else if (im[k]) b = b | (18'd3 << (2*k));
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    registers = v.board;
    start     = 1'b1;
    sbq.push_back(v);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the start edge; optionally disturbs board and start mid-scan
  task automatic runScan(input bit disturb, output int lat);
    int cnt;
    cnt   = 0;
    lat   = -1;
    e_lat = -1;
    while (cnt < 40 && lat < 0) begin
      @(posedge clk);
      cnt++;
      #1;
      if (e_lat < 0 && (e_valid || e_no_move)) begin
        e_lat   = cnt;
        e_row_s = e_row;
        e_col_s = e_col;
      end
      if (move_valid || no_move) lat = cnt;
      if (disturb) begin
        start = (cnt == 4 || cnt == 9);
        if (cnt == 4) registers = brd(9'b000010000, 9'd0, 9'd0);
      end
    end
    start = 1'b0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: got no result expected one within 40 edges");
      reset = 1'b1;
      #2 reset = 1'b0;
    end
  endtask

  task automatic checkOutput(input int lat);
    vec_t v;
    int   bad;
    v = sbq.pop_front();
    check("latency",    lat,        v.lat);
    check("move_valid", move_valid, v.valid);
    check("no_move",    no_move,    v.nomove);
    check("xoro",       xoro,       v.valid ? 2'b10 : 2'b00);
    check("row",        row,        v.row);
    check("col",        col,        v.col);
    check("busy",       busy,       1'b1);
    check("easy_lat",   e_lat,      v.elat);
    check("easy_row",   e_row_s,    v.erow);
    check("easy_col",   e_col_s,    v.ecol);
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (move_valid !== v.valid || no_move !== v.nomove || row !== v.row || col !== v.col || busy !== 1'b1)
        bad++;
    end
    check("hold_stable", bad, 0);
  endtask

  task automatic ackAndCheck(input bit with_start);
    @(negedge clk);
    move_ack = 1'b1;
    start    = with_start;
    @(posedge clk);
    #1;
    move_ack = 1'b0;
    start    = 1'b0;
    check("ack_busy",  busy, 1'b0);
    check("ack_outs",  {move_valid, no_move, xoro, row, col}, 8'd0);
    check("ack_ebusy", e_busy, 1'b0);
  endtask

  initial begin
    int lat;
    vecs[0] = '{brd(9'd0, 9'd0, 9'd0),                          1, 0, 2'd1, 2'd1, 19, 2'd1, 2'd1, 10};
    vecs[1] = '{brd(9'b000000011, 9'b000011000, 9'd0),          1, 0, 2'd0, 2'd2, 3,  2'd0, 2'd2, 3};
    vecs[2] = '{brd(9'b000010000, 9'b000100100, 9'd0),          1, 0, 2'd2, 2'd2, 18, 2'd0, 2'd0, 11};
    vecs[3] = '{brd(9'b110001101, 9'b001110010, 9'd0),          0, 1, 2'd0, 2'd0, 27, 2'd0, 2'd0, 18};
    vecs[4] = '{brd(9'b000001001, 9'b000010010, 9'd0),          1, 0, 2'd2, 2'd0, 7,  2'd2, 2'd0, 7};
    vecs[5] = '{brd(9'd0, 9'd0, 9'b000010001),                  1, 0, 2'd0, 2'd2, 21, 2'd0, 2'd2, 12};
    vecs[6] = '{brd(9'b001001110, 9'b100110001, 9'd0),          1, 0, 2'd2, 2'd1, 27, 2'd2, 2'd1, 18};
    vecs[7] = '{brd(9'd0, 9'b000000110, 9'd0),                  1, 0, 2'd0, 2'd0, 10, 2'd1, 2'd1, 10};

    reset     = 1'b1;
    start     = 1'b0;
    move_ack  = 1'b0;
    registers = 18'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_outs", {move_valid, no_move, xoro, row, col}, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // Ack stray outside DONE must not matter
    @(negedge clk);
    move_ack = 1'b1;
    @(negedge clk);
    move_ack = 1'b0;
    check("idle_ack_busy", busy, 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      runScan(1'b0, lat);
      checkOutput(lat);
      ackAndCheck(i == 3);
      @(negedge clk);
      check("stays_idle", busy, 1'b0);
    end

    // Board change and extra start pulses during the scan are ignored
    applyStimulus(vecs[0]);
    runScan(1'b1, lat);
    checkOutput(lat);
    ackAndCheck(1'b0);

    // Asynchronous reset in the middle of a scan
    @(negedge clk);
    registers = 18'd0;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_outs", {move_valid, no_move, xoro, row, col}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(vecs[0]);
    runScan(1'b0, lat);
    checkOutput(lat);
    ackAndCheck(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
